fir_decim_buffer: RTL and testbench
===================================

FIR_DECIM_BUFFER -- requirements
Module: fir_decim_buffer

Interface
REQ-001 Parameter DECIM, default 4: decimation factor; legal values 1, 2, 4, 8 or 16.
REQ-002 Parameter FIFO_DEPTH, default 4: output FIFO entries; legal values 2, 4 or 8.
REQ-003 system1000  input  1: the single clock; all state is updated on its rising edge.
REQ-004 system1000_rstn  input  1: reset, asynchronous assert, active-low.
REQ-005 in_data  input  16 signed: filtered sample taken from the FIR output (output_0).
REQ-006 in_valid  input  1: in_data is a valid sample this cycle.
REQ-007 out_data  output  16 signed: decimated sample at the FIFO head.
REQ-008 out_valid  output  1: out_data holds a valid sample.
REQ-009 out_ready  input  1: the consumer accepts out_data this cycle.
REQ-010 overflow  output  1: sticky flag; a decimated sample has been dropped.
REQ-011 clr_ovf  input  1: synchronous clear of overflow.

Function
REQ-012 Samples SHALL be accepted only on cycles where in_valid=1; in_valid=0 cycles change neither the accumulator nor the phase counter.
REQ-013 A phase counter SHALL count accepted samples 0..DECIM-1 and wrap to 0 after DECIM-1.
REQ-014 The accumulator SHALL be 16+log2(DECIM) bits signed and SHALL sum the DECIM accepted samples of one phase without overflow.
REQ-015 On the DECIM-th accepted sample, the block SHALL compute the dump value as (accumulator + in_data) arithmetically shifted right by log2(DECIM).
REQ-016 On the same DECIM-th sample, the accumulator SHALL reload to 0, so phases never overlap.
REQ-017 The dump value SHALL be pushed into the FIFO in the same cycle.
REQ-018 The pushed value SHALL be visible on out_data with out_valid=1 one cycle later when the FIFO was empty; latency is 1 clock.
REQ-019 When DECIM=1, every accepted sample SHALL pass through unchanged with 1-cycle latency.
REQ-020 out_valid SHALL equal "FIFO not empty", and out_data SHALL equal the FIFO head.
REQ-021 A pop SHALL occur when out_valid=1 and out_ready=1 in the same cycle.
REQ-022 out_data and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 Push to a full FIFO with no pop in that cycle: the value SHALL be dropped, the FIFO SHALL be unchanged, and overflow SHALL be set to 1 from the next cycle.
REQ-024 Push to a full FIFO with a pop in the same cycle: the push SHALL be accepted and the count SHALL stay unchanged.
REQ-025 Push and pop in the same cycle on a non-empty, non-full FIFO: the count SHALL be unchanged and order SHALL be preserved.
REQ-026 The FIFO SHALL be first-in first-out, with read and write pointers wrapping modulo FIFO_DEPTH.
REQ-027 When clr_ovf=1 and a drop occur in the same cycle, the drop SHALL win and overflow SHALL remain 1.

Reset
REQ-028 Asserting system1000_rstn=0 SHALL immediately and asynchronously clear the accumulator, phase counter, FIFO pointers and count, and overflow.
REQ-029 During reset, out_valid=0, out_data=0 and overflow=0.
REQ-030 Reset asserted mid-phase SHALL discard the partial sum.
REQ-031 After reset, the first accepted sample SHALL start a new phase at count 0.
REQ-032 Reset SHALL be deasserted synchronously to system1000 by the integrating level.

Configuration
REQ-033 With FIR_DECIM_ROUND_EN defined, the dump value SHALL add 2^(log2(DECIM)-1) before the shift (round half up); for DECIM=1 no offset is added.
REQ-034 Without FIR_DECIM_ROUND_EN defined, the dump value SHALL use a plain arithmetic shift (floor).
REQ-035 The result SHALL fit in 16 bits in both builds; no saturation logic is required.

Verification
REQ-036 DECIM=4, rounding off; feed 1,2,3,4 with in_valid=1 and out_ready=1 -> out_data=2 and out_valid=1 for exactly one cycle, starting 1 cycle after the sample 4.
REQ-037 DECIM=4, rounding on; feed 1,2,3,4 -> out_data=3. Feed -1,-1,-1,-2 -> rounding off gives -2, rounding on gives -1.
REQ-038 DECIM=4; feed 4x 32767 then 4x -32768 -> out_data=32767 then -32768, in both builds.
REQ-039 DECIM=1, FIFO_DEPTH=4, out_ready=0; feed 10,20,30,40,50 -> FIFO holds 10..40 and overflow=1 after 50. Then out_ready=1 -> out_data sequence is 10,20,30,40 and out_valid drops. Pulse clr_ovf -> overflow=0.
REQ-040 DECIM=1, FIFO full, out_ready=1; push 99 in the same cycle as a pop -> no overflow, and 99 emerges last.
REQ-041 DECIM=4; feed 2 samples with gaps of in_valid=0, assert reset mid-phase, then feed 8,8,8,8 -> out_data=8, the pre-reset samples have no effect, and outputs are 0 during reset.

Source files
------------

// File: rtl/fir_decim_buffer.sv
// Decimating accumulator (sum of DECIM samples, shifted by log2(DECIM)) feeding a small output FIFO.
// Defining FIR_DECIM_ROUND_EN selects round-half-up instead of floor for the dump value.
module fir_decim_buffer #(
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               system1000,
    input  logic               system1000_rstn,
    input  logic signed [15:0] in_data,
    input  logic               in_valid,
    output logic signed [15:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overflow,
    input  logic               clr_ovf
);

    localparam int SHIFT = $clog2(DECIM);
    localparam int AW    = 16 + SHIFT;
    localparam int PW    = (SHIFT == 0) ? 1 : SHIFT;
    localparam int PTRW  = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
`ifdef FIR_DECIM_ROUND_EN
    localparam int ROUND = (2 ** SHIFT) / 2;
`else
    localparam int ROUND = 0;
`endif

    logic signed [AW-1:0] acc_reg;
    logic [PW-1:0]        phase_reg;
    logic signed [AW-1:0] sum_next;
    logic signed [AW:0]   biased;
    logic signed [15:0]   dump;
    logic                 last;

    logic signed [15:0]   mem [FIFO_DEPTH];
    logic [PTRW-1:0]      wr_ptr_reg;
    logic [PTRW-1:0]      rd_ptr_reg;
    logic [CW-1:0]        count_reg;
    logic                 overflow_reg;

    logic full, empty, push, pop, wr_en, drop;

    // Sum never overflows AW bits; one extra bit absorbs the rounding offset.
    assign sum_next = acc_reg + AW'(in_data);
    assign biased   = (AW + 1)'(sum_next) + (AW + 1)'(ROUND);
    assign dump     = 16'(biased >>> SHIFT);
    assign last     = (phase_reg == PW'(DECIM - 1));

    assign full  = (count_reg == CW'(FIFO_DEPTH));
    assign empty = (count_reg == '0);
    assign push  = in_valid && last;
    assign pop   = !empty && out_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            acc_reg   <= '0;
            phase_reg <= '0;
        end else if (in_valid) begin
            if (last) begin
                acc_reg   <= '0;
                phase_reg <= '0;
            end else begin
                acc_reg   <= sum_next;
                phase_reg <= phase_reg + PW'(1);
            end
        end
    end

    // Storage carries no reset; out_data is gated by the emptiness test instead.
    always_ff @(posedge system1000) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= dump;
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTRW'(1);
            end
            if (wr_en && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !wr_en) begin
                count_reg <= count_reg - CW'(1);
            end
            // A drop outranks a simultaneous clear.
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clr_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr_reg];
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Scoreboard bench: two instances (DECIM=4 and DECIM=1, FIFO_DEPTH=4) checked against an
// arithmetic reference model; honours FIR_DECIM_ROUND_EN for the expected dump values.
module tb_fir_decim_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic signed [15:0] in_data   [2];
    logic               in_valid  [2];
    logic               out_ready [2];
    logic               clr_ovf   [2];
    logic signed [15:0] out_data  [2];
    logic               out_valid [2];
    logic               overflow  [2];

    fir_decim_buffer #(.DECIM(4), .FIFO_DEPTH(4)) u_d4 (
        .system1000(clk), .system1000_rstn(rst_n),
        .in_data(in_data[0]), .in_valid(in_valid[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .overflow(overflow[0]), .clr_ovf(clr_ovf[0])
    );

    fir_decim_buffer #(.DECIM(1), .FIFO_DEPTH(4)) u_d1 (
        .system1000(clk), .system1000_rstn(rst_n),
        .in_data(in_data[1]), .in_valid(in_valid[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .overflow(overflow[1]), .clr_ovf(clr_ovf[1])
    );

    localparam int DEPTH = 4;

    // Stimulus-side model: running phase sums and the value due for the next edge.
    int  ph_sum   [2];
    int  ph_cnt   [2];
    bit  pend_v   [2];
    int  pend_val [2];
    // Monitor-side model: expected FIFO contents and overflow flag.
    int  exp_q    [2][$];
    bit  exp_ovf  [2];
    int  checks = 0;
    int  errors = 0;

    function automatic int decim_of(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Mean of the phase: floor division, or round half up when rounding is built in.
    function automatic int ref_dump(int sum, int d);
        int s, q;
        if (d == 1) return sum;
        s = sum;
`ifdef FIR_DECIM_ROUND_EN
        s = s + d / 2;
`endif
        q = s / d;
        if ((s % d != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    task automatic check(string name, int i, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %0d, expected %0d", name, i, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                check("rst_out_valid", i, int'(out_valid[i]), 0);
                check("rst_out_data", i, int'(out_data[i]), 0);
                check("rst_overflow", i, int'(overflow[i]), 0);
                exp_q[i].delete();
                exp_ovf[i] = 1'b0;
            end else begin
                bit pop, drop;
                check("out_valid", i, int'(out_valid[i]), (exp_q[i].size() != 0) ? 1 : 0);
                if (exp_q[i].size() != 0 && out_valid[i])
                    check("out_data", i, int'(out_data[i]), exp_q[i][0]);
                check("overflow", i, int'(overflow[i]), int'(exp_ovf[i]));
                pop  = (exp_q[i].size() != 0) && out_ready[i];
                drop = pend_v[i] && (exp_q[i].size() == DEPTH) && !pop;
                if (pop) begin
                    $display("dut%0d pop %0d", i, exp_q[i][0]);
                    void'(exp_q[i].pop_front());
                end
                if (pend_v[i] && !drop) exp_q[i].push_back(pend_val[i]);
                if (drop) exp_ovf[i] = 1'b1;
                else if (clr_ovf[i]) exp_ovf[i] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            pend_v[i]   = 1'b0;
            in_valid[i] = 1'b0;
            clr_ovf[i]  = 1'b0;
        end
    endtask

    task automatic send(int i, int d);
        in_valid[i] = 1'b1;
        in_data[i]  = 16'(d);
        ph_sum[i]   = ph_sum[i] + d;
        ph_cnt[i]   = ph_cnt[i] + 1;
        if (ph_cnt[i] == decim_of(i)) begin
            pend_v[i]   = 1'b1;
            pend_val[i] = ref_dump(ph_sum[i], decim_of(i));
            ph_sum[i]   = 0;
            ph_cnt[i]   = 0;
        end
    endtask

    task automatic do_reset(int n);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ph_sum[i] = 0;
            ph_cnt[i] = 0;
            pend_v[i] = 1'b0;
        end
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic feed(int i, int a, int b, int c, int d);
        send(i, a); tick();
        send(i, b); tick();
        send(i, c); tick();
        send(i, d); tick();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_data[i] = '0; in_valid[i] = 1'b0; clr_ovf[i] = 1'b0; out_ready[i] = 1'b1;
            ph_sum[i] = 0; ph_cnt[i] = 0; pend_v[i] = 1'b0; pend_val[i] = 0;
            exp_ovf[i] = 1'b0;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // DECIM=4: averages, rounding direction on negatives, full-scale extremes
        feed(0, 1, 2, 3, 4);                 repeat (3) tick();
        feed(0, -1, -1, -1, -2);             repeat (3) tick();
        feed(0, 32767, 32767, 32767, 32767);
        feed(0, -32768, -32768, -32768, -32768);
        repeat (3) tick();
        // partial phase with gaps, then reset discards it
        send(0, 5); tick(); tick();
        send(0, 7); tick(); tick();
        do_reset(2);
        feed(0, 8, 8, 8, 8);                 repeat (3) tick();

        // DECIM=1: fill with no consumer, overflow, drain, clear
        out_ready[1] = 1'b0;
        send(1, 10); tick(); send(1, 20); tick(); send(1, 30); tick();
        send(1, 40); tick(); send(1, 50); tick();
        tick();
        out_ready[1] = 1'b1;
        repeat (6) tick();
        clr_ovf[1] = 1'b1; tick();
        tick();
        // full FIFO, push concurrent with pop is accepted
        out_ready[1] = 1'b0;
        feed(1, 1, 2, 3, 4);
        out_ready[1] = 1'b1;
        send(1, 99); tick();
        repeat (6) tick();
        // drop coincident with clear keeps overflow set
        out_ready[1] = 1'b0;
        feed(1, 5, 6, 7, 8);
        send(1, 9); clr_ovf[1] = 1'b1; tick();
        tick();
        out_ready[1] = 1'b1;
        repeat (6) tick();
        clr_ovf[1] = 1'b1; tick();

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                out_ready[i] = ($urandom % 3) != 0;
                if (($urandom % 4) != 0) send(i, int'($urandom_range(65535)) - 32768);
                clr_ovf[i] = ($urandom % 20) == 0;
            end
            tick();
            if (($urandom % 700) == 0) do_reset(2);
        end

        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        repeat (10) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
